param_stall_pipeline: RTL

PARAM_STALL_PIPELINE -- requirements
Module: param_stall_pipeline

---
 rtl/param_stall_pipeline.sv | 104 ++++++++++
 1 files changed

// File: rtl/param_stall_pipeline.sv
// param_stall_pipeline: DEPTH-stage valid/allow pipeline with per-stage stalls.
// Ports: clk, rst_n (async low), validin/datain/allowin (upstream), stall[DEPTH],
//   flush, allowout/validout/dataout (downstream), count (valid stage population).
// Optional macro PIPE_FLUSH_EN: flush drops all in-flight items at the next edge.
module param_stall_pipeline #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       validin,
    input  logic [WIDTH-1:0]           datain,
    output logic                       allowin,
    input  logic [DEPTH-1:0]           stall,
    input  logic                       flush,
    input  logic                       allowout,
    output logic                       validout,
    output logic [WIDTH-1:0]           dataout,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH+1);

    logic [DEPTH-1:0] v_q, v_d;
    logic [WIDTH-1:0] d_q [DEPTH];
    logic [DEPTH:0]   allow;
    logic [DEPTH-1:0] in_v;
    logic [DEPTH-1:0] ready_go;
    logic [DEPTH-1:0] load;
    logic             flush_act;

`ifdef PIPE_FLUSH_EN
    assign flush_act = flush;
`else
    // Port kept for a uniform interface; folded away when the feature is off.
    assign flush_act = flush & 1'b0;
`endif

    assign ready_go = ~stall;

    // Allow chain resolves from the output end so backpressure reaches
    // stage 0 within the same cycle.
    always_comb begin
        allow        = '0;
        allow[DEPTH] = allowout;
        for (int i = DEPTH-1; i >= 0; i--) begin
            allow[i] = !v_q[i] || (ready_go[i] && allow[i+1]);
        end
    end

    always_comb begin
        in_v    = '0;
        in_v[0] = validin;
        for (int i = 1; i < DEPTH; i++) begin
            in_v[i] = v_q[i-1] && ready_go[i-1];
        end
    end

    always_comb begin
        v_d  = v_q;
        load = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (allow[i]) begin
                v_d[i] = in_v[i];
            end
            load[i] = in_v[i] && allow[i] && !flush_act;
        end
        if (flush_act) begin
            v_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
        end else begin
            v_q <= v_d;
        end
    end

    // Payload registers carry no reset; validity lives only in v_q.
    always_ff @(posedge clk) begin
        if (load[0]) begin
            d_q[0] <= datain;
        end
        for (int i = 1; i < DEPTH; i++) begin
            if (load[i]) begin
                d_q[i] <= d_q[i-1];
            end
        end
    end

    always_comb begin
        count = '0;
        for (int i = 0; i < DEPTH; i++) begin
            count = count + CW'(v_q[i]);
        end
    end

    assign allowin  = allow[0] && !flush_act;
    assign validout = v_q[DEPTH-1] && ready_go[DEPTH-1] && !flush_act;
    assign dataout  = d_q[DEPTH-1];

endmodule
